sst_dump_streamer: RTL and testbench

- PI-side engine that reads a contiguous range of the 8 KB save-state window (mapper regs, PPU/APU snapshot, OAM, mapper memory) through the save-state controller's address/data port.
- Packs the bytes into 16-bit little-endian words, buffers them in a small FIFO for the PI readout path, and keeps a running byte checksum.
- Sits directly downstream of the save-state controller's read data output and upstream of the PI transfer logic.

---
 rtl/sst_pkg.sv | 21 ++
 rtl/sst_word_fifo.sv | 52 +++++
 rtl/sst_dump_streamer.sv | 183 ++++++++++++++++++
 tb/tb_sst_dump_streamer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sst_pkg.sv
// Shared definitions for the save-state dump path: address width, region map,
// pad byte and the streamer FSM states.
package sst_pkg;

    localparam int SST_ADDR_W = 13;

    localparam logic [12:0] SST_REG_BASE  = 13'h000;
    localparam logic [12:0] SST_SNIF_BASE = 13'h080;
    localparam logic [12:0] SST_OAM_BASE  = 13'h100;
    localparam logic [12:0] SST_MEM_BASE  = 13'h200;

    localparam logic [7:0] SST_PAD = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } sst_state_e;

endpackage

// File: rtl/sst_word_fifo.sv
// Small synchronous word FIFO; flush empties it in one clock and wins over
// push and pop. Push when full and pop when empty are dropped.
module sst_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     sys_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !i_flush && (r_count != (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sst_dump_streamer.sv
// Reads a range of the save-state window byte by byte, packs little-endian
// 16-bit words into a FIFO for the PI side and keeps a running byte sum.
module sst_dump_streamer
    import sst_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [12:0] base,
    input  logic [13:0] len,
    input  logic        abort,
    output logic [12:0] sst_addr,
    output logic        sst_rd,
    input  logic [7:0]  sst_di,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CR_W  = 8;
    localparam int IF_W  = 3;

    sst_state_e              r_state;
    sst_state_e              w_next_state;
    logic [SST_ADDR_W-1:0]   r_addr;
    logic [13:0]             r_remain;
    logic [RD_LAT-1:0]       r_pipe;
    logic [IF_W-1:0]         r_inflight;
    logic [7:0]              r_pack_lo;
    logic                    r_pack_vld;
    logic [15:0]             r_sum;
    logic                    r_done;
    logic                    r_aborting;

    logic [CNT_W-1:0]        w_count;
    logic [15:0]             w_push_data;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_abort;
    logic                    w_ret;
    logic                    w_ret_use;
    logic                    w_credit;
    logic                    w_empty_next;
    logic                    w_issue;
    logic                    w_pad_push;
    logic                    w_finish;

    assign w_abort   = abort && (r_state != ST_IDLE);
    assign w_pop     = (w_count != '0) && word_ready && !w_abort;
    assign w_ret     = r_pipe[RD_LAT-1];
    // A byte landing in the abort clock or afterwards belongs to a cancelled dump.
    assign w_ret_use = w_ret && !r_aborting && !w_abort;

    // Each unpopped byte costs one unit of credit, whether inflight, held or queued.
    assign w_credit = (CR_W'(r_inflight) + CR_W'(r_pack_vld) + (CR_W'(w_count) << 1))
                      < CR_W'(2 * FIFO_DEPTH);

    assign w_empty_next = (w_count == '0) || ((w_count == CNT_W'(1)) && w_pop);

    assign w_push      = (w_ret_use && r_pack_vld) || w_pad_push;
    assign w_push_data = w_pad_push ? {SST_PAD, r_pack_lo} : {sst_di, r_pack_lo};

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_pad_push   = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (len != '0)) w_next_state = ST_ISSUE;
                else if (start)           w_finish     = 1'b1;
            end
            ST_ISSUE: begin
                w_issue = w_credit;
                if (w_abort)                               w_next_state = ST_WAIT;
                else if (w_credit && (r_remain == 14'd1))  w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_abort && (r_inflight == '0)) begin
                    if (r_aborting) begin
                        w_next_state = ST_IDLE;
                    end else if (r_pack_vld) begin
                        w_pad_push   = 1'b1;
                        w_next_state = ST_DRAIN;
                    end else if (w_empty_next) begin
                        w_finish     = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_abort) begin
                    w_next_state = ST_WAIT;
                end else if (w_empty_next) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_pipe     <= '0;
            r_inflight <= '0;
            r_pack_lo  <= '0;
            r_pack_vld <= 1'b0;
            r_sum      <= '0;
            r_done     <= 1'b0;
            r_aborting <= 1'b0;
        end else begin
            r_pipe     <= (r_pipe << 1) | RD_LAT'(w_issue);
            r_inflight <= r_inflight + IF_W'(w_issue) - IF_W'(w_ret);
            r_done     <= w_finish;
            if ((r_state == ST_IDLE) && start) begin
                r_addr     <= base;
                r_remain   <= len;
                r_sum      <= '0;
                r_pack_vld <= 1'b0;
                r_aborting <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + 1'b1;
                    r_remain <= r_remain - 1'b1;
                end
                if (w_abort) begin
                    r_remain   <= '0;
                    r_aborting <= 1'b1;
                    r_pack_vld <= 1'b0;
                end else if (w_ret_use) begin
                    r_sum <= r_sum + {8'h00, sst_di};
                    if (!r_pack_vld) begin
                        r_pack_lo  <= sst_di;
                        r_pack_vld <= 1'b1;
                    end else begin
                        r_pack_vld <= 1'b0;
                    end
                end else if (w_pad_push) begin
                    r_pack_vld <= 1'b0;
                end
            end
        end
    end

    sst_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_push    (w_push),
        .i_din     (w_push_data),
        .i_pop     (w_pop),
        .i_flush   (w_abort),
        .o_dout    (word),
        .o_count   (w_count)
    );

    assign sst_addr   = r_addr;
    assign sst_rd     = w_issue;
    assign word_valid = (w_count != '0);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign sum        = r_sum;

endmodule

// File: tb/tb_sst_dump_streamer.sv
// Directed and randomized dumps against a byte-array model of the save-state
// window; expected words, addresses and sums come from that model.
module tb_sst_dump_streamer;

    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk        = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        start      = 1'b0;
    logic [12:0] base       = '0;
    logic [13:0] len        = '0;
    logic        abort      = 1'b0;
    logic        word_ready = 1'b0;
    logic [7:0]  sst_di     = '0;
    logic [12:0] sst_addr;
    logic        sst_rd;
    logic [15:0] word;
    logic        word_valid;
    logic        busy;
    logic        done;
    logic [15:0] sum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  mem [0:8191];
    logic        h_vld  [0:RD_LAT];
    logic [12:0] h_addr [0:RD_LAT];

    logic [12:0] rd_q[$];
    logic [15:0] got_q[$];
    int          done_cnt;
    int          first_rd_cyc;
    int          last_rd_cyc;

    logic [15:0] exp_q[$];
    logic [12:0] exp_addr_q[$];
    logic [15:0] exp_sum;

    sst_dump_streamer #(
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .base       (base),
        .len        (len),
        .abort      (abort),
        .sst_addr   (sst_addr),
        .sst_rd     (sst_rd),
        .sst_di     (sst_di),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .done       (done),
        .sum        (sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus memory model: a read seen in cycle c is answered in cycle c+RD_LAT.
    always @(negedge clk) begin
        if (sst_rd) begin
            rd_q.push_back(sst_addr);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
        end
        if (word_valid && word_ready) got_q.push_back(word);
        if (done) done_cnt++;
        for (int i = RD_LAT; i > 0; i--) begin
            h_vld[i]  = h_vld[i-1];
            h_addr[i] = h_addr[i-1];
        end
        h_vld[0]  = sst_rd;
        h_addr[0] = sst_addr;
        sst_di = h_vld[RD_LAT] ? mem[h_addr[RD_LAT]] : 8'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        got_q.delete();
        done_cnt     = 0;
        first_rd_cyc = -1;
        last_rd_cyc  = -1;
    endtask

    task automatic build_model(input logic [12:0] b, input logic [13:0] l);
        logic [7:0]  lo;
        logic [12:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        exp_sum = '0;
        lo = '0;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 13'(i);
            exp_addr_q.push_back(a);
            exp_sum = exp_sum + 16'(mem[a]);
            if (i % 2 == 1) exp_q.push_back({mem[a], lo});
            else            lo = mem[a];
        end
        if (l[0]) exp_q.push_back({8'hFF, lo});
    endtask

    task automatic pulse_start(input logic [12:0] b, input logic [13:0] l, output int s_cyc);
        start = 1'b1;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
        s_cyc = cyc - 1;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 20 clocks then ready
    task automatic run_dump(input string tag, input logic [12:0] b, input logic [13:0] l,
                            input int mode);
        int s;
        int n;
        clear_mon();
        build_model(b, l);
        word_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        pulse_start(b, l, s);
        n = 0;
        while (busy && n < 3000) begin
            if (mode == 2 && n == 20) begin
                check({tag, "_stall_reads"}, rd_q.size(), 2 * FIFO_DEPTH);
                check({tag, "_stall_rd_low"}, sst_rd, 0);
                check({tag, "_stall_valid"}, word_valid, 1);
            end
            if (mode == 1)      word_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) word_ready = (n >= 20);
            tick();
            n++;
        end
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        #1;
        check({tag, "_rd_count"}, rd_q.size(), exp_addr_q.size());
        for (int i = 0; i < rd_q.size() && i < exp_addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), rd_q[i], exp_addr_q[i]);
        check({tag, "_word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_done_cnt"}, done_cnt, 1);
        if (mode == 0) begin
            check({tag, "_first_rd"}, first_rd_cyc, s + 1);
            check({tag, "_rd_span"}, last_rd_cyc - first_rd_cyc, int'(l) - 1);
        end
        tick();
    endtask

    initial begin
        int s;
        int n;
        logic [12:0] b;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        for (int i = 0; i <= RD_LAT; i++) begin
            h_vld[i]  = 1'b0;
            h_addr[i] = '0;
        end
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", sst_rd, 0);
        check("rst_addr", sst_addr, 0);
        check("rst_valid", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        sys_rst_n = 1'b1;
        tick();

        // Snapshot region, eight known bytes
        for (int i = 0; i < 8; i++) mem[13'h080 + 13'(i)] = 8'(i + 1);
        run_dump("t1", 13'h080, 14'd8, 0);
        check("t1_sum_const", sum, 16'h0024);

        // Address wrap with an odd length
        mem[13'h1FFE] = 8'hAA;
        mem[13'h1FFF] = 8'hBB;
        mem[13'h0000] = 8'hCC;
        run_dump("t2", 13'h1FFE, 14'd3, 0);
        check("t2_sum_const", sum, 16'h0231);

        // Consumer back-pressure limits reads to the credit window
        run_dump("t3", 13'($urandom), 14'd64, 2);

        // Zero-length start
        clear_mon();
        word_ready = 1'b1;
        pulse_start(13'($urandom), 14'd0, s);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_sum", sum, 0);
        repeat (4) tick();
        check("t4_no_reads", rd_q.size(), 0);
        check("t4_done_cnt", done_cnt, 1);

        // Early abort: the byte returning in the abort clock is discarded too
        clear_mon();
        word_ready = 1'b0;
        pulse_start(13'($urandom), 14'd16, s);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_rd_low", sst_rd, 0);
        check("t5_valid", word_valid, 0);
        check("t5_busy_hold", busy, 1);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("t5_busy_end", busy, 0);
        @(negedge clk);
        #1;
        check("t5_done_cnt", done_cnt, 0);
        check("t5_rd_count", rd_q.size(), 3);
        check("t5_sum", sum, 0);
        tick();
        run_dump("t5_after", 13'($urandom), 14'($urandom_range(1, 40)), 1);

        // Late abort with a full FIFO: partial sum of the eight returned bytes holds
        b = 13'($urandom);
        build_model(b, 14'd8);
        clear_mon();
        word_ready = 1'b0;
        pulse_start(b, 14'd40, s);
        repeat (15) tick();
        check("t5b_valid_before", word_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5b_valid_after", word_valid, 0);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("t5b_busy_end", busy, 0);
        @(negedge clk);
        #1;
        check("t5b_sum", sum, exp_sum);
        check("t5b_done_cnt", done_cnt, 0);
        check("t5b_rd_count", rd_q.size(), 2 * FIFO_DEPTH);
        tick();

        // Asynchronous reset in the middle of a dump
        clear_mon();
        pulse_start(13'($urandom), 14'd40, s);
        repeat (10) begin
            word_ready = 1'($urandom_range(0, 1));
            tick();
        end
        sys_rst_n = 1'b0;
        #1;
        check("t6_rd", sst_rd, 0);
        check("t6_addr", sst_addr, 0);
        check("t6_valid", word_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_sum", sum, 0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        run_dump("t6_after", 13'($urandom), 14'($urandom_range(1, 40)), 1);

        // Randomized dumps
        for (int k = 0; k < 6; k++)
            run_dump($sformatf("rnd%0d", k), 13'($urandom), 14'($urandom_range(1, 48)),
                     $urandom_range(0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
